// File: rtl/al_multi_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | al_multi_controller: keypad entry/commit sequencer for a multi-alarm     |
// | clock. Optional macro ALC_CANCEL_EN: KP_PLUS during entry cancels it.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module al_multi_controller #(
  parameter  int N_ALARMS  = 2,
  parameter  int N_DIGITS  = 4,
  parameter  int TIMEOUT_S = 10,
  localparam int SW        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
  localparam int DW        = $clog2(N_DIGITS + 1)
) (
  input  logic          clk256,
  input  logic          reset,
  input  logic          one_second,
  input  logic [7:0]    key,
  output logic          load_alarm,
  output logic [SW-1:0] alarm_sel,
  output logic          show_alarm,
  output logic          alc_shift,
  output logic          load_new_time,
  output logic          show_keyboard,
  output logic [DW-1:0] digit_count
);

  // Keypad scan codes (local copy of the keycodes.vh encoding)
  localparam logic [7:0] KP_0            = 8'h00;
  localparam logic [7:0] KP_9            = 8'h09;
  localparam logic [7:0] KP_STAR         = 8'h0A;
  localparam logic [7:0] KP_MINUS        = 8'h0B;
  localparam logic [7:0] KP_PLUS         = 8'h0C;
  localparam logic [7:0] KP_KEY_RELEASED = 8'hFE;
  localparam logic [7:0] KP_INVALID      = 8'hFF;

  localparam logic [DW-1:0] MAX_DIGITS = DW'(N_DIGITS);
  localparam logic [SW-1:0] LAST_SLOT  = SW'(N_ALARMS - 1);
  localparam logic [7:0]    RELOAD     = 8'(TIMEOUT_S);

  typedef enum logic [3:0] {
    S_IDLE               = 4'd0,
    S_KEY_STORE          = 4'd1,
    S_KEY_HOLD           = 4'd2,
    S_KEY_RELEASE        = 4'd3,
    S_ENTRY              = 4'd4,
    S_COMMIT_ALARM       = 4'd5,
    S_COMMIT_TIME        = 4'd6,
    S_SHOW_ALARM         = 4'd7,
    S_SHOW_ALARM_RELEASE = 4'd8
  } state_t;

  state_t     state;
  logic [7:0] timeout;
  logic       is_digit;

  assign is_digit = (key >= KP_0) && (key <= KP_9);

  always_ff @(posedge clk256) begin
    if (reset) begin
      state         <= S_IDLE;
      timeout       <= 8'd0;
      load_alarm    <= 1'b0;
      load_new_time <= 1'b0;
      alc_shift     <= 1'b0;
      show_alarm    <= 1'b0;
      show_keyboard <= 1'b0;
      alarm_sel     <= '0;
      digit_count   <= '0;
    end else begin
      load_alarm    <= 1'b0;
      load_new_time <= 1'b0;
      alc_shift     <= 1'b0;

      // Countdown runs in every state; a reload below overrides it.
      if (one_second && (timeout != 8'd0)) begin
        timeout <= timeout - 8'd1;
      end

      case (state)
        S_IDLE: begin
          digit_count <= '0;
          show_alarm  <= 1'b0;
          if (key == KP_STAR) begin
            state         <= S_SHOW_ALARM;
            show_alarm    <= 1'b1;
            show_keyboard <= 1'b0;
          end else if (is_digit) begin
            state         <= S_KEY_STORE;
            show_keyboard <= 1'b1;
          end
        end

        S_KEY_STORE: begin
          if (digit_count < MAX_DIGITS) begin
            alc_shift   <= 1'b1;
            digit_count <= digit_count + 1'b1;
          end
          state <= S_KEY_HOLD;
        end

        S_KEY_HOLD: begin
          if (key == KP_KEY_RELEASED) begin
            state <= S_KEY_RELEASE;
          end
        end

        S_KEY_RELEASE: begin
          if (key == KP_INVALID) begin
            state   <= S_ENTRY;
            timeout <= RELOAD;
          end
        end

        S_ENTRY: begin
          if (timeout == 8'd0) begin
            state         <= S_IDLE;
            digit_count   <= '0;
            show_keyboard <= 1'b0;
          end else if (key == KP_STAR) begin
            state <= S_COMMIT_ALARM;
          end else if (key == KP_MINUS) begin
            state <= S_COMMIT_TIME;
`ifdef ALC_CANCEL_EN
          end else if (key == KP_PLUS) begin
            state         <= S_IDLE;
            digit_count   <= '0;
            show_keyboard <= 1'b0;
`endif
          end else if (is_digit) begin
            state <= S_KEY_STORE;
          end
        end

        S_COMMIT_ALARM: begin
          load_alarm    <= (digit_count == MAX_DIGITS);
          state         <= S_IDLE;
          show_keyboard <= 1'b0;
          digit_count   <= '0;
        end

        S_COMMIT_TIME: begin
          load_new_time <= (digit_count == MAX_DIGITS);
          state         <= S_IDLE;
          show_keyboard <= 1'b0;
          digit_count   <= '0;
        end

        S_SHOW_ALARM: begin
          show_keyboard <= 1'b0;
          if (key == KP_KEY_RELEASED) begin
            state      <= S_SHOW_ALARM_RELEASE;
            show_alarm <= 1'b0;
          end
        end

        S_SHOW_ALARM_RELEASE: begin
          if (key == KP_INVALID) begin
            state     <= S_IDLE;
            alarm_sel <= (alarm_sel == LAST_SLOT) ? '0 : alarm_sel + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_al_multi_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_al_multi_controller: randomized keypad sessions with scoreboard check |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_al_multi_controller;

  localparam int N_ALARMS  = 2;
  localparam int N_DIGITS  = 4;
  localparam int TIMEOUT_S = 10;
  localparam int SW        = 1;
  localparam int DW        = 3;

  localparam logic [7:0] KP_STAR         = 8'h0A;
  localparam logic [7:0] KP_MINUS        = 8'h0B;
  localparam logic [7:0] KP_PLUS         = 8'h0C;
  localparam logic [7:0] KP_KEY_RELEASED = 8'hFE;
  localparam logic [7:0] KP_INVALID      = 8'hFF;

  logic          clk256 = 1'b0;
  logic          reset = 1'b1;
  logic          one_second = 1'b0;
  logic [7:0]    key = KP_INVALID;
  logic          load_alarm, show_alarm, alc_shift, load_new_time, show_keyboard;
  logic [SW-1:0] alarm_sel;
  logic [DW-1:0] digit_count;

  always #5 clk256 = ~clk256;

  al_multi_controller #(
    .N_ALARMS (N_ALARMS),
    .N_DIGITS (N_DIGITS),
    .TIMEOUT_S(TIMEOUT_S)
  ) dut (
    .clk256       (clk256),
    .reset        (reset),
    .one_second   (one_second),
    .key          (key),
    .load_alarm   (load_alarm),
    .alarm_sel    (alarm_sel),
    .show_alarm   (show_alarm),
    .alc_shift    (alc_shift),
    .load_new_time(load_new_time),
    .show_keyboard(show_keyboard),
    .digit_count  (digit_count)
  );

  // kind: 0 = shift, 1 = alarm load, 2 = time load
  typedef struct {
    int kind;
    int cnt;
    int sel;
  } ev_t;
  ev_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  // Abstract model: digits collected, active slot, entry flag, seconds left
  int m_count = 0;
  int m_sel   = 0;
  int m_timer = 0;
  bit m_entry = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event
  logic [2:0] mon_p;
  logic [2:0] mon_prev = 3'b000;
  ev_t        mon_e;
  always @(negedge clk256) begin
    if (reset) begin
      mon_prev = 3'b000;
    end else begin
      mon_p = {load_new_time, load_alarm, alc_shift};
      if (mon_p != 3'b000) begin
        chk("pulse_onehot", $countones(mon_p), 1);
        chk("pulse_single_cycle", int'(mon_p & mon_prev), 0);
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_pulse: got pulses %b expected none at %0t", mon_p, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("pulse_kind", alc_shift ? 0 : (load_alarm ? 1 : 2), mon_e.kind);
          if (mon_e.kind == 0) chk("shift_digit_count", int'(digit_count), mon_e.cnt);
          if (mon_e.kind == 1) chk("load_alarm_sel", int'(alarm_sel), mon_e.sel);
        end
      end
      mon_prev = mon_p;
    end
  end

  task automatic push_ev(input int kind, input int cnt, input int sel);
    ev_t e;
    e.kind = kind;
    e.cnt  = cnt;
    e.sel  = sel;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [7:0] k, input int n);
    key = k;
    repeat (n) @(negedge clk256);
  endtask

  task automatic settle(input string name);
    chk({name, "_show_keyboard"}, int'(show_keyboard), int'(m_entry));
    chk({name, "_digit_count"}, int'(digit_count), m_entry ? m_count : 0);
    chk({name, "_show_alarm"}, int'(show_alarm), 0);
    chk({name, "_alarm_sel"}, int'(alarm_sel), m_sel);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_load_alarm"}, int'(load_alarm), 0);
    chk({name, "_load_new_time"}, int'(load_new_time), 0);
    chk({name, "_alc_shift"}, int'(alc_shift), 0);
    chk({name, "_show_alarm"}, int'(show_alarm), 0);
    chk({name, "_show_keyboard"}, int'(show_keyboard), 0);
    chk({name, "_alarm_sel"}, int'(alarm_sel), 0);
    chk({name, "_digit_count"}, int'(digit_count), 0);
  endtask

  // sec_on_reload puts a one_second pulse on the reload cycle; it must be lost
  task automatic press_digit(input int d, input bit sec_on_reload);
    if (m_count < N_DIGITS) begin
      m_count++;
      push_ev(0, m_count, 0);
    end
    m_entry = 1;
    m_timer = TIMEOUT_S;
    drive(8'(d), $urandom_range(2, 4));
    drive(KP_KEY_RELEASED, 2);
    key = KP_INVALID;
    one_second = sec_on_reload;
    @(negedge clk256);
    one_second = 1'b0;
    @(negedge clk256);
    settle("digit");
  endtask

  task automatic press_cmd(input logic [7:0] k);
    drive(k, 1);
    drive(KP_KEY_RELEASED, 2);
    drive(KP_INVALID, 2);
  endtask

  task automatic press_star();
    if (m_entry) begin
      if (m_count == N_DIGITS) push_ev(1, 0, m_sel);
      m_entry = 0;
      m_count = 0;
      press_cmd(KP_STAR);
      settle("commit_alarm");
    end else begin
      drive(KP_STAR, 3);
      chk("held_show_alarm", int'(show_alarm), 1);
      chk("held_show_keyboard", int'(show_keyboard), 0);
      chk("held_alarm_sel", int'(alarm_sel), m_sel);
      drive(KP_KEY_RELEASED, 2);
      drive(KP_INVALID, 2);
      m_sel = (m_sel + 1) % N_ALARMS;
      settle("show_alarm_done");
    end
  endtask

  task automatic press_minus();
    if (m_entry) begin
      if (m_count == N_DIGITS) push_ev(2, 0, 0);
      m_entry = 0;
      m_count = 0;
    end
    press_cmd(KP_MINUS);
    settle("commit_time");
  endtask

  task automatic press_plus();
`ifdef ALC_CANCEL_EN
    if (m_entry) begin
      m_entry = 0;
      m_count = 0;
    end
`endif
    press_cmd(KP_PLUS);
    settle("plus");
  endtask

  task automatic wait_seconds(input int n);
    for (int i = 0; i < n; i++) begin
      one_second = 1'b1;
      @(negedge clk256);
      one_second = 1'b0;
      repeat (2) @(negedge clk256);
      if (m_timer > 0) m_timer--;
      if (m_timer == 0 && m_entry) begin
        m_entry = 0;
        m_count = 0;
      end
    end
    settle("seconds");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk256);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk256);

    // Four digits then alarm commit into slot 0
    for (int d = 1; d <= 4; d++) press_digit(d, 1'b0);
    press_star();

    // Browse alarm slots twice: 0 -> 1 -> 0
    press_star();
    press_star();

    // Short entry committed as time: shifts only, no load
    press_digit(1, 1'b0);
    press_digit(2, 1'b0);
    press_minus();

    // Timeout: still in entry after 9 seconds, idle after the 10th
    press_digit(5, 1'b1);
    wait_seconds(9);
    wait_seconds(1);

    // Six digits saturate at N_DIGITS, then a time load
    for (int d = 0; d < 6; d++) press_digit(d, 1'b0);
    press_minus();

    // Plus inside an entry
    press_digit(7, 1'b0);
    press_plus();
    press_minus();

    // Reset while a key is held, with slot 1 selected
    press_star();
    m_count++;
    push_ev(0, m_count, 0);
    drive(8'd3, 3);
    reset = 1'b1;
    key = KP_INVALID;
    @(negedge clk256);
    check_all_zero("reset_in_hold");
    reset = 1'b0;
    m_count = 0;
    m_entry = 0;
    m_sel   = 0;
    m_timer = 0;
    @(negedge clk256);
    settle("after_reset");

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: press_digit(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
        5, 6:          press_star();
        7:             press_minus();
        8:             press_plus();
        default:       wait_seconds(int'($urandom_range(1, 12)));
      endcase
    end

    repeat (5) @(negedge clk256);
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/al_multi_controller.md
AL_MULTI_CONTROLLER -- requirements
Module: al_multi_controller

Interface
REQ-001 The block SHALL have parameter N_ALARMS, default 2, number of alarm slots (1..16).
REQ-002 The block SHALL have parameter N_DIGITS, default 4, digits required for a valid entry (1..8).
REQ-003 The block SHALL have parameter TIMEOUT_S, default 10, entry inactivity timeout in seconds (1..255).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; SW = max(1, clog2(N_ALARMS)) and DW = clog2(N_DIGITS+1).
REQ-005 clk256  input  1  system clock, all state on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 one_second  input  1  single-cycle pulse once per second.
REQ-008 key  input  8  keypad scan code per keycodes.vh (KP_0..KP_9, KP_STAR, KP_MINUS, KP_PLUS, KP_KEY_RELEASED, KP_INVALID).
REQ-009 load_alarm  output  1  one-cycle pulse: commit shifted digits to slot alarm_sel.
REQ-010 alarm_sel  output  SW  selected alarm slot.
REQ-011 show_alarm  output  1  display slot alarm_sel.
REQ-012 alc_shift  output  1  one-cycle pulse: shift current digit into entry register.
REQ-013 load_new_time  output  1  one-cycle pulse: commit digits to current time.
REQ-014 show_keyboard  output  1  display entry register.
REQ-015 digit_count  output  DW  digits shifted in current entry, saturating at N_DIGITS.

Function
REQ-016 All outputs SHALL be registered; state, digit_count, alarm_sel and timeout counter SHALL update on the clk256 edge.
REQ-017 States SHALL be IDLE, KEY_STORE, KEY_HOLD, KEY_RELEASE, ENTRY, COMMIT_ALARM, COMMIT_TIME, SHOW_ALARM, SHOW_ALARM_RELEASE.
REQ-018 IDLE: KP_STAR -> SHOW_ALARM; digit -> KEY_STORE with show_keyboard=1; other codes ignored; digit_count=0.
REQ-019 KEY_STORE (one cycle): if digit_count<N_DIGITS pulse alc_shift and increment digit_count, else no pulse; -> KEY_HOLD.
REQ-020 KEY_HOLD: KP_KEY_RELEASED -> KEY_RELEASE; KEY_RELEASE: KP_INVALID -> ENTRY, reloading timeout counter to TIMEOUT_S.
REQ-021 ENTRY priority: timeout==0 -> IDLE; else KP_STAR -> COMMIT_ALARM; else KP_MINUS -> COMMIT_TIME; else digit -> KEY_STORE.
REQ-022 COMMIT_ALARM/COMMIT_TIME (one cycle): pulse load_alarm/load_new_time only if digit_count==N_DIGITS, else no pulse; -> IDLE, show_keyboard=0, digit_count=0.
REQ-023 SHOW_ALARM: show_alarm=1, show_keyboard=0; KP_KEY_RELEASED -> SHOW_ALARM_RELEASE; KP_INVALID there -> IDLE and alarm_sel increments modulo N_ALARMS.
REQ-024 Timeout counter SHALL decrement on one_second when nonzero in any state; reload in the same cycle SHALL win over decrement.
REQ-025 Entering IDLE by timeout SHALL clear digit_count and show_keyboard with no load pulse.
REQ-026 load_alarm, load_new_time, alc_shift SHALL never assert for more than one cycle, nor together.
REQ-027 With N_ALARMS=1, alarm_sel SHALL remain 0.

Reset
REQ-028 reset SHALL force state IDLE, all outputs 0, alarm_sel 0, digit_count 0, timeout 0 on the next edge, mid-operation included, with no pulse.

Configuration
REQ-029 Macro ALC_CANCEL_EN defined: KP_PLUS in ENTRY SHALL -> IDLE clearing digit_count and show_keyboard, no load; undefined: KP_PLUS in ENTRY SHALL be ignored.

Verification
REQ-030 Keys 1,2,3,4 (each with release+KP_INVALID), KP_STAR -> 4 alc_shift pulses, digit_count=4, one load_alarm pulse with alarm_sel=0.
REQ-031 KP_STAR press/release twice from IDLE (N_ALARMS=2) -> show_alarm high while held, alarm_sel 0->1->0.
REQ-032 Keys 1,2 then KP_MINUS -> 2 alc_shift pulses, no load_new_time, return to IDLE, digit_count=0.
REQ-033 Key 5 then 10 one_second pulses with no key -> IDLE after 10th pulse, no load pulses; pulse on reload cycle not counted.
REQ-034 Six digits, N_DIGITS=4, then KP_MINUS -> exactly 4 alc_shift pulses, one load_new_time pulse.
REQ-035 reset asserted in KEY_HOLD -> all outputs 0 next cycle, state IDLE; with ALC_CANCEL_EN, KP_PLUS in ENTRY -> IDLE, no load.
